// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encodings and widths.
package uart_tx_arbiter_pkg;

  localparam int STATE_SIZE = 2;
  localparam int BYTE_W     = 8;

  typedef enum logic [STATE_SIZE-1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or after ptr, wrapping.
module uart_tx_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan offsets from the farthest down to zero so the closest hit wins.
  always_comb begin
    int j;
    gnt_oh = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      j = (int'(ptr) + off) % NUM_REQ;
      if (req_vec[j]) begin
        gnt_oh    = '0;
        gnt_oh[j] = 1'b1;
        idx       = IDX_W'(j);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX channel between NUM_REQ byte sources.
// Handshake: a source may strobe wr[i] only in a cycle where ready[i]=1;
// that cycle's wr_data slice is taken, and a strobe seen while ready[i]=0
// is dropped (never queued). The grant is held per burst until req drops,
// and an owner that sits ready-but-silent for TIMEOUT cycles is revoked.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr,
  input  logic [BYTE_W*NUM_REQ-1:0] wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ready,
  input  logic                      busy,
  output logic                      new_data_tx,
  output logic [BYTE_W-1:0]         data_tx,
  output logic                      timeout_evt,
  output logic [STATE_SIZE-1:0]     dbg_state
);

  localparam int  IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int  CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int  GCNT_W   = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int  G_LAST   = (GUARD_CYCLES > 1) ? GUARD_CYCLES - 1 : 0;
  localparam int  TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit  TMO_EN   = (TIMEOUT != 0);

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner_next;
  logic [CNT_W-1:0]   idle_cnt;
  logic [GCNT_W-1:0]  guard_cnt;
  logic [NUM_REQ-1:0] mask;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_vec (req & ~mask),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  // Ready is the registered grant qualified by the FSM and live busy.
  always_comb begin
    ready      = gnt & {NUM_REQ{(state == ST_OWNED) && !busy}};
    owner_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    dbg_state  = state;
  end

  // Arbitration FSM with guard, idle-timeout and revocation mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt         <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      guard_cnt   <= '0;
      mask        <= '0;
      new_data_tx <= 1'b0;
      data_tx     <= '0;
      timeout_evt <= 1'b0;
    end else begin
      new_data_tx <= 1'b0;
      timeout_evt <= 1'b0;
      // A revoked source becomes eligible again once it has dropped req.
      mask        <= mask & req;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt      <= pick_oh;
            owner    <= pick_idx;
            idle_cnt <= '0;
            state    <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (wr[owner] && ready[owner]) begin
            new_data_tx <= 1'b1;
            data_tx     <= wr_data[owner*BYTE_W +: BYTE_W];
            idle_cnt    <= '0;
            guard_cnt   <= '0;
            state       <= ST_GUARD;
          end else if (!req[owner]) begin
            gnt    <= '0;
            rr_ptr <= owner_next;
            state  <= ST_IDLE;
          end else if (ready[owner]) begin
            // Only ready-and-silent cycles count; busy freezes the counter.
            if (TMO_EN && (idle_cnt == CNT_W'(TMO_LAST))) begin
              gnt         <= '0;
              timeout_evt <= 1'b1;
              mask[owner] <= 1'b1;
              rr_ptr      <= owner_next;
              state       <= ST_IDLE;
            end else if (idle_cnt != '1) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        ST_GUARD: begin
          if (guard_cnt == GCNT_W'(G_LAST)) begin
            state <= ST_OWNED;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=2, GUARD_CYCLES=2, TIMEOUT=16).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [15:0] wr_data;
  logic [1:0]  gnt;
  logic [1:0]  ready;
  logic        busy;
  logic        new_data_tx;
  logic [7:0]  data_tx;
  logic        timeout_evt;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (2),
    .GUARD_CYCLES (2),
    .TIMEOUT      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .wr          (wr),
    .wr_data     (wr_data),
    .gnt         (gnt),
    .ready       (ready),
    .busy        (busy),
    .new_data_tx (new_data_tx),
    .data_tx     (data_tx),
    .timeout_evt (timeout_evt),
    .dbg_state   (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int idx, input string tag);
    int n;
    n = 0;
    while (ready[idx] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(ready[idx]), 32'd1);
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b, input string tag, output int t);
    wait_ready(idx, {tag, "_rdy"});
    wr[idx]             = 1'b1;
    wr_data[idx*8 +: 8] = b;
    step();
    wr = 2'b00;
    t  = cyc;
    chk({tag, "_strobe"}, 32'(new_data_tx), 32'd1);
    chk({tag, "_data"}, 32'(data_tx), 32'(b));
  endtask

  // Directed sequence
  initial begin
    int t0, t1, t2, ns, nt, nr;
    rst = 1'b1; req = 2'b00; wr = 2'b00; wr_data = 16'h0000; busy = 1'b0;
    step(); step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_strobe", 32'(new_data_tx), 32'd0);
    chk("rst_data", 32'(data_tx), 32'd0);
    chk("rst_tmo", 32'(timeout_evt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // 1. Single source, three bytes
    rst = 1'b0; req = 2'b01;
    step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_ready", 32'(ready), 32'h1);
    send_byte(0, 8'h05, "t1_b0", t0);
    chk("t1_guard_ready", 32'(ready), 32'h0);
    send_byte(0, 8'h10, "t1_b1", t1);
    send_byte(0, 8'hAA, "t1_b2", t2);
    chk("t1_gap01", 32'(t1 - t0), 32'd3);
    chk("t1_gap12", 32'(t2 - t1), 32'd3);
    step();
    chk("t1_one_cycle", 32'(new_data_tx), 32'd0);
    req = 2'b00;
    step();
    chk("t1_hold_in_guard", 32'(gnt), 32'h1);
    step();
    chk("t1_release", 32'(gnt), 32'h0);
    chk("t1_data_hold", 32'(data_tx), 32'hAA);

    // 2. Contention and round-robin order
    rst = 1'b1; step(); rst = 1'b0;
    req = 2'b11;
    step();
    chk("t2_first", 32'(gnt), 32'h1);
    req = 2'b10;
    step();
    chk("t2_release0", 32'(gnt), 32'h0);
    step();
    chk("t2_second", 32'(gnt), 32'h2);
    send_byte(1, 8'h3C, "t2_b", t0);
    wait_ready(1, "t2_back_owned");
    req = 2'b01;
    step();
    chk("t2_release1", 32'(gnt), 32'h0);
    req = 2'b11;
    step();
    chk("t2_third", 32'(gnt), 32'h1);

    // Non-owner strobe is ignored
    wr = 2'b10; wr_data[15:8] = 8'h55;
    step();
    wr = 2'b00;
    chk("t5_nonowner_strobe", 32'(new_data_tx), 32'd0);
    chk("t5_nonowner_data", 32'(data_tx), 32'h3C);

    // 3. Busy stall for 50 cycles
    busy = 1'b1;
    step();
    chk("t3_ready_busy", 32'(ready), 32'h0);
    ns = 0; nt = 0; nr = 0;
    for (int i = 0; i < 50; i++) begin
      wr = (i % 10 == 5) ? 2'b01 : 2'b00;
      wr_data[7:0] = 8'hEE;
      step();
      if (new_data_tx) ns++;
      if (timeout_evt) nt++;
      if (ready != 2'b00) nr++;
    end
    wr = 2'b00;
    chk("t3_no_strobe", 32'(ns), 32'd0);
    chk("t3_no_timeout", 32'(nt), 32'd0);
    chk("t3_no_ready", 32'(nr), 32'd0);
    chk("t3_still_owned", 32'(gnt), 32'h1);
    busy = 1'b0; wr = 2'b01; wr_data[7:0] = 8'h77;
    step();
    wr = 2'b00;
    chk("t3_after_strobe", 32'(new_data_tx), 32'd1);
    chk("t3_after_data", 32'(data_tx), 32'h77);

    // 4. Timeout revocation
    rst = 1'b1; req = 2'b00;
    step();
    rst = 1'b0; req = 2'b11;
    step();
    chk("t4_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t4_no_evt_yet", 32'(timeout_evt), 32'd0);
    end
    step();
    chk("t4_evt", 32'(timeout_evt), 32'd1);
    chk("t4_revoked", 32'(gnt), 32'h0);
    step();
    chk("t4_evt_pulse", 32'(timeout_evt), 32'd0);
    chk("t4_other", 32'(gnt), 32'h2);
    req = 2'b01;
    step();
    chk("t4_release1", 32'(gnt), 32'h0);
    step();
    chk("t4_masked_a", 32'(gnt), 32'h0);
    step();
    chk("t4_masked_b", 32'(gnt), 32'h0);
    req = 2'b00;
    step();
    req = 2'b01;
    step();
    chk("t4_regrant", 32'(gnt), 32'h1);

    // 5. wr together with req drop: byte issued, then release after guard
    wr = 2'b01; wr_data[7:0] = 8'hC3; req = 2'b00;
    step();
    wr = 2'b00;
    chk("t5_drop_strobe", 32'(new_data_tx), 32'd1);
    chk("t5_drop_data", 32'(data_tx), 32'hC3);
    chk("t5_drop_gnt0", 32'(gnt), 32'h1);
    step();
    chk("t5_drop_gnt1", 32'(gnt), 32'h1);
    step();
    chk("t5_drop_gnt2", 32'(gnt), 32'h1);
    step();
    chk("t5_drop_release", 32'(gnt), 32'h0);

    // rst in the middle of a guard window
    req = 2'b01;
    step();
    chk("t5_rst_gnt", 32'(gnt), 32'h1);
    wr = 2'b01; wr_data[7:0] = 8'h5A;
    step();
    chk("t5_rst_strobe_pre", 32'(new_data_tx), 32'd1);
    rst = 1'b1; wr_data[7:0] = 8'h99;
    step();
    wr = 2'b00;
    chk("t5_rst_gnt_clr", 32'(gnt), 32'h0);
    chk("t5_rst_strobe_clr", 32'(new_data_tx), 32'd0);
    chk("t5_rst_data_clr", 32'(data_tx), 32'h0);
    chk("t5_rst_tmo_clr", 32'(timeout_evt), 32'd0);
    chk("t5_rst_state", 32'(dbg_state), 32'd0);
    chk("t5_rst_ready", 32'(ready), 32'h0);
    rst = 1'b0; req = 2'b00;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
